countdown_timer: RTL
====================

Name: countdown_timer

Overview:
Parametrised, reloadable countdown timer. It is the next generation of the 4-bit start/stop/reset countdown block.
- Adds a programmable load value, pause/resume, a tick prescaler and an auto-reload (periodic) mode.
- Sits beside control FSMs as a generic timeout/alarm source; counter value is exported for display.

Parameters:
WIDTH, 4, counter width in bits
PRESCALE, 1, clock cycles per count tick (>=1); 1 = decrement every cycle
DEFAULT_LOAD, 2**WIDTH-1, reload register and counter value after reset

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
start  input  1  level; begin or resume counting
stop  input  1  level; pause counting
load  input  1  write load_value into reload register and counter
load_value  input  WIDTH  new reload value
auto_reload  input  1  1 = periodic mode, 0 = one-shot
counter  output  WIDTH  current count (registered)
alarm  output  1  expiry indication (registered)
running  output  1  high while state == RUN
warn  output  1  near-expiry flag (see Optional Feature)

Behaviour:
- One clock, single-edge design. All outputs registered.
- Reset (reset==0 at an edge):
  - state=IDLE, counter=DEFAULT_LOAD, reload_q=DEFAULT_LOAD
  - alarm=0, running=0, warn=0, prescaler=0
- FSM states: IDLE, RUN, PAUSED, EXPIRED.
- Per-edge priority: reset > load > stop > start > tick.
- load (any state): reload_q<=load_value, counter<=load_value, alarm<=0, state<=IDLE, prescaler<=0.
- stop:
  - RUN -> PAUSED, counter frozen, prescaler frozen
  - No effect in IDLE, PAUSED or EXPIRED
  - start and stop in the same cycle: stop wins
- start:
  - IDLE or PAUSED -> RUN
  - EXPIRED -> RUN with counter<=reload_q, alarm<=0, prescaler<=0
  - No effect in RUN
- Prescaler:
  - Counts 0..PRESCALE-1 only while in RUN; tick = (presc==PRESCALE-1).
  - Cleared on entering RUN from IDLE or EXPIRED; preserved across PAUSED.
  - With PRESCALE=1 a tick occurs every RUN cycle: start sampled at edge k gives the first decrement at edge k+1.
- Tick in RUN, counter>1: counter<=counter-1.
- Tick in RUN, counter==1:
  - auto_reload=0: counter<=0, alarm<=1, state<=EXPIRED. alarm stays high until start, load or reset.
  - auto_reload=1: counter<=reload_q, alarm<=1 for exactly one cycle, state stays RUN.
  - Period is therefore reload_q ticks.
- Counter==0 while in RUN (only when reload_q==0), on tick:
  - one-shot: alarm<=1, EXPIRED
  - auto-reload: alarm pulses every tick, counter stays 0
- No wrap-around: the counter never decrements below 0.
- Reset mid-count overrides everything, including the alarm, on that edge.
- Reset in PAUSED returns to IDLE with DEFAULT_LOAD.

Optional Feature:
Macro CDT_WARN_EN.
- Defined: adds parameter WARN_LEVEL (default 2). warn = registered (state==RUN && counter!=0 && counter<=WARN_LEVEL).
- Undefined: warn is tied to 0 and no comparator logic is generated.
- Port list is identical either way.

Decomposition:
- Package countdown_pkg holds:
  - state enum cdt_state_t {IDLE, RUN, PAUSED, EXPIRED}
  - localparam defaults for WIDTH, PRESCALE and WARN_LEVEL
- One sub-module, cdt_prescaler (enable, clear, tick out; parametrised by PRESCALE), instantiated once.
- Remaining FSM and counter logic stay in countdown_timer.

Test Plan:
- WIDTH=4, PRESCALE=1, start=1 from reset -> counter 15..0 over 15 cycles; alarm=1 on the edge counter hits 0; state EXPIRED; alarm held.
- Expired, then reset=0 for one cycle, then start -> counter=15, alarm=0, counting resumes; 9 ticks later counter=6, stop=1 -> counter holds 6 and running=0. start again -> 5 on the next edge.
- load=1 with load_value=3, auto_reload=1, start -> sequence 3,2,1,3,2,1…; alarm is a 1-cycle pulse coincident with each reload to 3.
- PRESCALE=4, load 2, start -> counter drops every 4th cycle; alarm 8 cycles after start. Pausing for 5 cycles mid-period does not lose prescaler phase.
- start and stop asserted together in RUN -> PAUSED. load during RUN -> IDLE, counter=load_value, alarm=0. load_value=0 with start -> alarm on the first tick.
- CDT_WARN_EN, WARN_LEVEL=2, load 5, start -> warn high only at counter 2 and 1, low at 0 and when PAUSED. Without the macro, warn stays 0 throughout.

Source files
------------

// File: rtl/countdown_pkg.sv
// countdown_pkg
// Shared types and default parameter values for the countdown timer slice.
//   cdt_state_t              : timer FSM state encoding
//   CDT_WIDTH_DEFAULT        : default counter width
//   CDT_PRESCALE_DEFAULT     : default clock cycles per count tick
//   CDT_WARN_LEVEL_DEFAULT   : default near-expiry threshold (CDT_WARN_EN builds)
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } cdt_state_t;

  localparam int CDT_WIDTH_DEFAULT      = 4;
  localparam int CDT_PRESCALE_DEFAULT   = 1;
  localparam int CDT_WARN_LEVEL_DEFAULT = 2;

endpackage

// File: rtl/cdt_prescaler.sv
// cdt_prescaler
// Divides the clock into count ticks: the phase counter runs 0..PRESCALE-1
// while enabled and holds its value while disabled.
//   clk       : rising-edge clock
//   reset     : synchronous active-low reset (phase <= 0)
//   enable_i  : advance the phase this cycle
//   clear_i   : force phase to 0 (wins over enable_i)
//   tick_o    : high when the current phase is the last one (PRESCALE-1)
module cdt_prescaler
  import countdown_pkg::*;
#(
  parameter int PRESCALE = CDT_PRESCALE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;

  // With PRESCALE == 1 the phase is pinned at 0, so every enabled cycle ticks.
  assign tick_o = (presc_q == LAST);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    presc_d = presc_q;
    if (clear_i) begin
      presc_d = '0;
    end else if (enable_i) begin
      presc_d = tick_o ? '0 : presc_q + PW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer
// Reloadable countdown timer with pause/resume, tick prescaler and an
// optional periodic (auto-reload) mode. All outputs are registered.
// Optional feature: define CDT_WARN_EN to add parameter WARN_LEVEL and a
// registered near-expiry flag; otherwise warn is tied low.
//   clk          : rising-edge clock
//   reset        : synchronous active-low reset
//   start        : level; begin or resume counting
//   stop         : level; pause counting (wins over start)
//   load         : write load_value into reload register and counter, go IDLE
//   load_value   : new reload value
//   auto_reload  : 1 = periodic, 0 = one-shot
//   counter      : current count
//   alarm        : expiry indication (held in one-shot, 1-cycle pulse in periodic)
//   running      : high while the FSM is in RUN
//   warn         : high in RUN while 0 < counter <= WARN_LEVEL (CDT_WARN_EN only)
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int               WIDTH        = CDT_WIDTH_DEFAULT,
  parameter int               PRESCALE     = CDT_PRESCALE_DEFAULT,
  parameter logic [WIDTH-1:0] DEFAULT_LOAD = {WIDTH{1'b1}}
`ifdef CDT_WARN_EN
  ,
  parameter int               WARN_LEVEL   = CDT_WARN_LEVEL_DEFAULT
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] counter,
  output logic             alarm,
  output logic             running,
  output logic             warn
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  cdt_state_t       state_q,   state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] reload_q,  reload_d;
  logic             alarm_q,   alarm_d;
  logic             running_q, running_d;
  logic             presc_en;
  logic             presc_clr;
  logic             tick;
  logic             go;

  // stop masks start in every state.
  assign go = start && !stop;

  cdt_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable_i (presc_en),
    .clear_i  (presc_clr),
    .tick_o   (tick)
  );

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    reload_d  = reload_q;
    alarm_d   = alarm_q;
    presc_en  = 1'b0;
    presc_clr = 1'b0;

    if (load) begin
      reload_d  = load_value;
      counter_d = load_value;
      alarm_d   = 1'b0;
      state_d   = IDLE;
      presc_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (go) begin
            state_d   = RUN;
            presc_clr = 1'b1;
          end
        end
        PAUSED: begin
          // Resume keeps the prescaler phase.
          if (go) state_d = RUN;
        end
        EXPIRED: begin
          if (go) begin
            state_d   = RUN;
            counter_d = reload_q;
            alarm_d   = 1'b0;
            presc_clr = 1'b1;
          end
        end
        RUN: begin
          // In RUN the alarm is only ever a pulse on the expiring tick.
          alarm_d = 1'b0;
          if (stop) begin
            state_d = PAUSED;
          end else begin
            presc_en = 1'b1;
            if (tick) begin
              if (counter_q > ONE) begin
                counter_d = counter_q - ONE;
              end else begin
                // counter is 1 or 0 (0 only when reload_q == 0): expiry.
                alarm_d = 1'b1;
                if (auto_reload) begin
                  counter_d = reload_q;
                end else begin
                  counter_d = '0;
                  state_d   = EXPIRED;
                end
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      counter_q <= DEFAULT_LOAD;
      reload_q  <= DEFAULT_LOAD;
      alarm_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      reload_q  <= reload_d;
      alarm_q   <= alarm_d;
      running_q <= running_d;
    end
  end

  assign counter = counter_q;
  assign alarm   = alarm_q;
  assign running = running_q;

`ifdef CDT_WARN_EN
  // Threshold truncated to counter width; values >= 2**WIDTH wrap.
  localparam logic [WIDTH-1:0] WARN_CMP = WIDTH'(WARN_LEVEL);

  logic warn_q, warn_d;

  // Evaluated on next-state values so the flag lines up with the registered count.
  assign warn_d = (state_d == RUN) && (counter_d != '0) && (counter_d <= WARN_CMP);

  always_ff @(posedge clk) begin
    if (!reset) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

endmodule
